prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, begins a load when sampled high in IDLE, DONE or ERR.
REQ-004 SHALL have port len, input, 8, number of program bytes, sampled with start; 0 means 256.
REQ-005 SHALL have port abort, input, 1, returns to IDLE from any state.
REQ-006 SHALL have ports in_valid (input, 1), in_data (input, 8), in_ready (output, 1): host byte stream handshake.
REQ-007 SHALL have ports ram_addr (output, 8), ram_data (output, 8), ram_wren (output, 1): CPU RAM write port.
REQ-008 SHALL have ports cpu_rst (output, 1, holds CPU in reset) and cpu_run (output, 1, one-cycle run pulse).
REQ-009 SHALL have ports busy, done, err (outputs, 1 each) and sum (output, 8, running byte sum).

Function
REQ-010 SHALL implement states IDLE, LOAD, CHECK, RUN, DONE, ERR.
REQ-011 SHALL go IDLE/DONE/ERR -> LOAD on start=1; latch len, clear address counter and sum to 0.
REQ-012 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in LOAD and CHECK.
REQ-013 SHALL, for each byte accepted in LOAD at edge k, drive ram_addr=counter, ram_data=byte, ram_wren=1 for exactly the cycle after edge k (registered), then increment counter.
REQ-014 SHALL increment the address counter modulo 256; with len=0, addresses 0..255 are written once each.
REQ-015 SHALL update sum = (sum + byte) mod 256 on every accepted byte, including in CHECK.
REQ-016 SHALL leave LOAD after the len-th accepted byte: to CHECK if CHECKSUM_EN is defined, else to RUN.
REQ-017 SHALL in RUN drive cpu_rst=0 and cpu_run=1 for exactly one cycle, then enter DONE.
REQ-018 SHALL hold done=1 and cpu_rst=0 in DONE until start or abort.
REQ-019 SHALL drive cpu_rst=1 in IDLE, LOAD, CHECK and ERR.
REQ-020 SHALL drive busy=1 in LOAD, CHECK and RUN only.
REQ-021 SHALL give abort priority over start and over a simultaneous byte acceptance; the aborted byte is not written.
REQ-022 SHALL ignore start while in LOAD, CHECK or RUN.
REQ-023 SHALL keep ram_wren=0 in every state other than the cycle of REQ-013.

Reset
REQ-024 SHALL on rstn=0 immediately enter IDLE, regardless of clock, including mid-load.
REQ-025 SHALL reset to: in_ready=0, ram_addr=0, ram_data=0, ram_wren=0, cpu_rst=1, cpu_run=0, busy=0, done=0, err=0, sum=0.
REQ-026 SHALL discard any partially loaded program after reset; no pending write completes.

Configuration
REQ-027 SHALL, with macro PROG_LOADER_CHECKSUM_EN defined, in CHECK accept one extra byte (not written to RAM); if updated sum==0 go RUN, else go ERR with err=1 until start or abort.
REQ-028 SHALL, without PROG_LOADER_CHECKSUM_EN, omit CHECK and ERR; err tied to 0.

Verification
REQ-029 SHALL cover: start, len=3, bytes 0x10,0x20,0x30 back-to-back -> writes addr0=0x10, addr1=0x20, addr2=0x30, one cycle each; cpu_run pulse one cycle after last write (no checksum); done=1.
REQ-030 SHALL cover: len=2, in_valid toggling with gaps -> only handshaken bytes written, addresses contiguous, ram_wren never high in gap cycles.
REQ-031 SHALL cover: len=0, 256 bytes 0x00..0xFF -> addresses 0..255 written, counter wraps to 0, sum=0x80 after last byte.
REQ-032 SHALL cover (CHECKSUM_EN): bytes 0x01,0x02 then check 0xFD -> RUN, done=1; check 0xFE -> err=1, cpu_run never pulses, cpu_rst stays 1.
REQ-033 SHALL cover: rstn low after 1 of 3 bytes -> all outputs at reset values asynchronously; abort same cycle as valid byte -> IDLE, no write.

Source files
------------

// File: rtl/prog_loader_if.sv
// Host byte-stream handshake and CPU RAM write port of the program loader.
// The loader takes the slave modport; the host/testbench side takes master.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_wren;

    modport slave  (input  in_valid, in_data,
                    output in_ready, ram_addr, ram_data, ram_wren);
    modport master (output in_valid, in_data,
                    input  in_ready, ram_addr, ram_data, ram_wren);
endinterface

// File: rtl/prog_loader.sv
// Streams a program into CPU RAM, then releases the CPU with a one-cycle run pulse.
// Define PROG_LOADER_CHECKSUM_EN to append a checksum byte that must bring the sum to 0.
module prog_loader (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [7:0]   len,
    input  logic         abort,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         cpu_run,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [7:0]   sum
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, DONE, ERR} state_t;

    state_t     state, state_nxt;
    logic [7:0] left;      // bytes still to load; 0 stands for 256
    logic [7:0] addr_cnt;
    logic       accept;
    logic       launch;
    logic [7:0] sum_nxt;

    assign sum_nxt = sum + bus.in_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt    = state;
        launch       = 1'b0;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        cpu_rst      = 1'b1;
        cpu_run      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            IDLE: launch = start;
            LOAD: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                accept       = bus.in_valid;
                if (accept && left == 8'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                accept       = bus.in_valid;
                if (accept) state_nxt = (sum_nxt == 8'd0) ? RUN : ERR;
            end
            ERR: begin
                err    = 1'b1;
                launch = start;
            end
`endif
            RUN: begin
                cpu_rst   = 1'b0;
                cpu_run   = 1'b1;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                launch  = start;
            end
            default: state_nxt = IDLE;
        endcase
        if (launch) state_nxt = LOAD;
        // Abort wins over start and over a byte handshaking on the same edge.
        if (abort) begin
            state_nxt = IDLE;
            launch    = 1'b0;
            accept    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            left         <= 8'd0;
            addr_cnt     <= 8'd0;
            sum          <= 8'd0;
            bus.ram_addr <= 8'd0;
            bus.ram_data <= 8'd0;
            bus.ram_wren <= 1'b0;
        end else begin
            bus.ram_wren <= 1'b0;
            if (launch) begin
                left     <= len;
                addr_cnt <= 8'd0;
                sum      <= 8'd0;
            end
            if (accept) sum <= sum_nxt;
            // Only program bytes reach RAM; the checksum byte only updates the sum.
            if (accept && state == LOAD) begin
                bus.ram_addr <= addr_cnt;
                bus.ram_data <= bus.in_data;
                bus.ram_wren <= 1'b1;
                addr_cnt     <= addr_cnt + 8'd1;
                left         <= left - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a cycle-by-cycle vector table plus directed
// sequences for the 256-byte wrap, async reset, abort and (optionally) checksum paths.
`timescale 1ns/1ps
module tb_prog_loader;
    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] len   = 8'd0;
    logic       cpu_rst, cpu_run, busy, done, err;
    logic [7:0] sum;

    int checks = 0;
    int errors = 0;

    prog_loader_if bus ();

    prog_loader dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .len     (len),
        .abort   (abort),
        .bus     (bus.slave),
        .cpu_rst (cpu_rst),
        .cpu_run (cpu_run),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .sum     (sum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       in_ready;
        logic       ram_wren;
        logic [7:0] ram_addr;
        logic [7:0] ram_data;
        logic       cpu_rst;
        logic       cpu_run;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] sum;
    } out_t;

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       abort;
        logic       valid;
        logic [7:0] data;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t o(input logic rdy, input logic wren, input logic [7:0] a,
                               input logic [7:0] d, input logic rst, input logic run,
                               input logic bsy, input logic dn, input logic er,
                               input logic [7:0] s);
        out_t r;
        r = '{rdy, wren, a, d, rst, run, bsy, dn, er, s};
        return r;
    endfunction

    function automatic out_t actual();
        out_t r;
        r = '{bus.in_ready, bus.ram_wren, bus.ram_addr, bus.ram_data,
              cpu_rst, cpu_run, busy, done, err, sum};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] l, input logic a,
                         input logic v, input logic [7:0] d);
        start        = s;
        len          = l;
        abort        = a;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [7:0] l, input logic a,
                       input logic v, input logic [7:0] d, input out_t e);
        vec_t x;
        x = '{s, l, a, v, d, e};
        vecs.push_back(x);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t rst_vals;
        rst_vals = o(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        drive(0, 8'd0, 0, 0, 8'h00);

        #2;
        check("reset_state", 32'(actual()), 32'(rst_vals));
        #10 rstn = 1'b1;
        tick();

`ifndef PROG_LOADER_CHECKSUM_EN
        // len=3 back-to-back load, then len=2 with gaps, a stray start, and abort.
        add(1, 8'd3, 0, 0, 8'h00, o(1, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 8'h00));
        add(0, 8'd0, 0, 1, 8'h10, o(1, 1, 8'h00, 8'h10, 1, 0, 1, 0, 0, 8'h10));
        add(0, 8'd0, 0, 1, 8'h20, o(1, 1, 8'h01, 8'h20, 1, 0, 1, 0, 0, 8'h30));
        add(0, 8'd0, 0, 1, 8'h30, o(0, 1, 8'h02, 8'h30, 0, 1, 1, 0, 0, 8'h60));
        add(0, 8'd0, 0, 0, 8'h00, o(0, 0, 8'h02, 8'h30, 0, 0, 0, 1, 0, 8'h60));
        add(0, 8'd0, 0, 1, 8'h55, o(0, 0, 8'h02, 8'h30, 0, 0, 0, 1, 0, 8'h60));
        add(1, 8'd2, 0, 0, 8'h00, o(1, 0, 8'h02, 8'h30, 1, 0, 1, 0, 0, 8'h00));
        add(0, 8'd0, 0, 0, 8'h00, o(1, 0, 8'h02, 8'h30, 1, 0, 1, 0, 0, 8'h00));
        add(0, 8'd0, 0, 1, 8'hA1, o(1, 1, 8'h00, 8'hA1, 1, 0, 1, 0, 0, 8'hA1));
        add(1, 8'd5, 0, 0, 8'hEE, o(1, 0, 8'h00, 8'hA1, 1, 0, 1, 0, 0, 8'hA1));
        add(0, 8'd0, 0, 0, 8'hEE, o(1, 0, 8'h00, 8'hA1, 1, 0, 1, 0, 0, 8'hA1));
        add(0, 8'd0, 0, 1, 8'h5F, o(0, 1, 8'h01, 8'h5F, 0, 1, 1, 0, 0, 8'h00));
        add(0, 8'd0, 0, 0, 8'h00, o(0, 0, 8'h01, 8'h5F, 0, 0, 0, 1, 0, 8'h00));
        add(0, 8'd0, 1, 0, 8'h00, o(0, 0, 8'h01, 8'h5F, 1, 0, 0, 0, 0, 8'h00));
        add(1, 8'd4, 1, 0, 8'h00, o(0, 0, 8'h01, 8'h5F, 1, 0, 0, 0, 0, 8'h00));
        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].len, vecs[i].abort, vecs[i].valid, vecs[i].data);
            tick();
            check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
        end
`endif

        // len=0: 256 bytes 0x00..0xFF land at addresses 0..255.
        drive(1, 8'd0, 0, 0, 8'h00);
        tick();
        check("sweep_load_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 256; i++) begin
            drive(0, 8'd0, 0, 1, 8'(i));
            tick();
            check($sformatf("sweep_write%0d", i),
                  32'({bus.ram_wren, bus.ram_addr, bus.ram_data}),
                  32'({1'b1, 8'(i), 8'(i)}));
        end
        check("sweep_sum", 32'(sum), 32'h80);
`ifndef PROG_LOADER_CHECKSUM_EN
        check("sweep_run", 32'(cpu_run), 32'd1);
`endif
        drive(0, 8'd0, 0, 0, 8'h00);
        tick();
        check("sweep_wren_clear", 32'(bus.ram_wren), 32'd0);
        drive(0, 8'd0, 1, 0, 8'h00);
        tick();
        check("sweep_abort", 32'(actual()), 32'(o(0, 0, 8'hFF, 8'hFF, 1, 0, 0, 0, 0, 8'h80)));

        // Asynchronous reset after the first of three bytes.
        drive(1, 8'd3, 0, 0, 8'h00);
        tick();
        drive(0, 8'd0, 0, 1, 8'h42);
        tick();
        check("rst_first_byte", 32'(actual()), 32'(o(1, 1, 8'h00, 8'h42, 1, 0, 1, 0, 0, 8'h42)));
        drive(0, 8'd0, 0, 1, 8'h43);
        #2 rstn = 1'b0;
        #1;
        check("rst_async", 32'(actual()), 32'(rst_vals));
        #2 rstn = 1'b1;
        tick();
        check("rst_no_resume", 32'(actual()), 32'(rst_vals));

        // Abort on the same edge as a valid byte: byte dropped, no write.
        drive(1, 8'd3, 0, 0, 8'h00);
        tick();
        drive(0, 8'd0, 0, 1, 8'h11);
        tick();
        check("abort_pre", 32'(actual()), 32'(o(1, 1, 8'h00, 8'h11, 1, 0, 1, 0, 0, 8'h11)));
        drive(0, 8'd0, 1, 1, 8'h22);
        tick();
        check("abort_byte_dropped", 32'(actual()), 32'(o(0, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0, 8'h11)));
        drive(0, 8'd0, 0, 0, 8'h00);
        tick();
        check("abort_idle_hold", 32'(actual()), 32'(o(0, 0, 8'h00, 8'h11, 1, 0, 0, 0, 0, 8'h11)));

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good checksum: 0x01 + 0x02 + 0xFD = 0x100 -> RUN then DONE.
        drive(1, 8'd2, 0, 0, 8'h00);
        tick();
        drive(0, 8'd0, 0, 1, 8'h01);
        tick();
        drive(0, 8'd0, 0, 1, 8'h02);
        tick();
        check("ck_check_state", 32'(actual()), 32'(o(1, 1, 8'h01, 8'h02, 1, 0, 1, 0, 0, 8'h03)));
        drive(0, 8'd0, 0, 1, 8'hFD);
        tick();
        check("ck_run", 32'(actual()), 32'(o(0, 0, 8'h01, 8'h02, 0, 1, 1, 0, 0, 8'h00)));
        drive(0, 8'd0, 0, 0, 8'h00);
        tick();
        check("ck_done", 32'(actual()), 32'(o(0, 0, 8'h01, 8'h02, 0, 0, 0, 1, 0, 8'h00)));

        // Bad checksum: 0x01 + 0x02 + 0xFE = 0x01 -> ERR, CPU stays in reset.
        drive(1, 8'd2, 0, 0, 8'h00);
        tick();
        check("ck_reload", 32'(actual()), 32'(o(1, 0, 8'h01, 8'h02, 1, 0, 1, 0, 0, 8'h00)));
        drive(0, 8'd0, 0, 1, 8'h01);
        tick();
        drive(0, 8'd0, 0, 1, 8'h02);
        tick();
        drive(0, 8'd0, 0, 1, 8'hFE);
        tick();
        check("ck_err", 32'(actual()), 32'(o(0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 1, 8'h01)));
        drive(0, 8'd0, 0, 0, 8'h00);
        tick();
        check("ck_err_hold", 32'(actual()), 32'(o(0, 0, 8'h01, 8'h02, 1, 0, 0, 0, 1, 8'h01)));
        drive(1, 8'd1, 0, 0, 8'h00);
        tick();
        check("ck_restart", 32'(actual()), 32'(o(1, 0, 8'h01, 8'h02, 1, 0, 1, 0, 0, 8'h00)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
